// File: rtl/l1_mshr_entry_ctrl.sv
// MSHR entry tracker: primary allocate, secondary merge, response accept and per-sub-entry replay.
// Optional feature: define MSHR_SECONDARY_MERGE_EN to allow secondary misses to merge into live entries.

module l1_mshr_entry #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          alloc,
  input  logic          merge,
  input  logic          rel,
  output logic          vld,
  output logic [CW-1:0] cnt
);
  // alloc only targets invalid entries and rel only the drained one, so the
  // priority order never has to arbitrate a real collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= 1'b0;
      cnt <= '0;
    end else if (rel) begin
      vld <= 1'b0;
      cnt <= '0;
    end else if (alloc) begin
      vld <= 1'b1;
      cnt <= CW'(1);
    end else if (merge) begin
      cnt <= cnt + CW'(1);
    end
  end
endmodule

module l1_mshr_entry_ctrl #(
  parameter int NUM_ENTRY = 4,
  parameter int NUM_SUB   = 4
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic                                           pri_valid_i,
  output logic                                           pri_ready_o,
  output logic [$clog2(NUM_ENTRY)-1:0]                   pri_idx_o,
  input  logic                                           sec_valid_i,
  output logic                                           sec_ready_o,
  input  logic [$clog2(NUM_ENTRY)-1:0]                   sec_idx_i,
  input  logic                                           rsp_valid_i,
  output logic                                           rsp_ready_o,
  input  logic [$clog2(NUM_ENTRY)-1:0]                   rsp_idx_i,
  output logic                                           out_valid_o,
  input  logic                                           out_ready_i,
  output logic [$clog2(NUM_ENTRY)-1:0]                   out_idx_o,
  output logic [((NUM_SUB > 1) ? $clog2(NUM_SUB) : 1)-1:0] out_sub_o,
  output logic                                           out_last_o,
  output logic [$clog2(NUM_ENTRY):0]                     used_o,
  output logic                                           full_o
);
  localparam int IW = $clog2(NUM_ENTRY);
  localparam int SW = (NUM_SUB > 1) ? $clog2(NUM_SUB) : 1;
  localparam int CW = $clog2(NUM_SUB + 1);
  localparam int UW = IW + 1;

  typedef enum logic {S_IDLE, S_DRAIN} state_t;

  state_t                        state;
  logic [IW-1:0]                 drn_idx;
  logic [SW-1:0]                 beat;
  logic [NUM_ENTRY-1:0]          ent_vld;
  logic [NUM_ENTRY-1:0][CW-1:0]  ent_cnt;
  logic [NUM_ENTRY-1:0]          alloc, merge, rel;
  logic                          pri_fire, sec_fire, rsp_fire, out_fire;

  for (genvar g = 0; g < NUM_ENTRY; g++) begin : g_ent
    l1_mshr_entry #(.CW(CW)) u_ent (
      .clk   (clk),
      .rst_n (rst_n),
      .alloc (alloc[g]),
      .merge (merge[g]),
      .rel   (rel[g]),
      .vld   (ent_vld[g]),
      .cnt   (ent_cnt[g])
    );
  end

  always_comb begin
    used_o = '0;
    for (int i = 0; i < NUM_ENTRY; i++) used_o = used_o + UW'(ent_vld[i]);
  end
  assign full_o      = (used_o == UW'(NUM_ENTRY));
  assign pri_ready_o = !full_o;

  // Scan high to low so the lowest free index wins.
  always_comb begin
    pri_idx_o = '0;
    for (int i = NUM_ENTRY - 1; i >= 0; i--) if (!ent_vld[i]) pri_idx_o = IW'(i);
  end

  assign rsp_ready_o = (state == S_IDLE) && ent_vld[rsp_idx_i];
  assign rsp_fire    = rsp_valid_i && rsp_ready_o;

`ifdef MSHR_SECONDARY_MERGE_EN
  // Entry being drained, or whose response is accepted now, is frozen so the
  // beat count latched for replay cannot move underneath it.
  assign sec_ready_o = ent_vld[sec_idx_i]
                    && (ent_cnt[sec_idx_i] < CW'(NUM_SUB))
                    && !((state == S_DRAIN) && (drn_idx == sec_idx_i))
                    && !(rsp_fire && (rsp_idx_i == sec_idx_i));
`else
  assign sec_ready_o = 1'b0;
`endif

  assign pri_fire    = pri_valid_i && pri_ready_o;
  assign sec_fire    = sec_valid_i && sec_ready_o;

  assign out_valid_o = (state == S_DRAIN);
  assign out_idx_o   = drn_idx;
  assign out_sub_o   = beat;
  assign out_last_o  = (state == S_DRAIN) && ((CW'(beat) + CW'(1)) == ent_cnt[drn_idx]);
  assign out_fire    = out_valid_o && out_ready_i;

  always_comb begin
    for (int i = 0; i < NUM_ENTRY; i++) begin
      alloc[i] = pri_fire && (pri_idx_o == IW'(i));
      merge[i] = sec_fire && (sec_idx_i == IW'(i));
      rel[i]   = out_fire && out_last_o && (drn_idx == IW'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      drn_idx <= '0;
      beat    <= '0;
    end else begin
      case (state)
        S_IDLE: if (rsp_fire) begin
          state   <= S_DRAIN;
          drn_idx <= rsp_idx_i;
          beat    <= '0;
        end
        S_DRAIN: if (out_ready_i) begin
          if (out_last_o) state <= S_IDLE;
          else            beat  <= beat + SW'(1);
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_l1_mshr_entry_ctrl.sv
// Bench for l1_mshr_entry_ctrl: directed scenarios plus random traffic against an entry-table model.
module tb_l1_mshr_entry_ctrl;
  localparam int NE = 4;
  localparam int NS = 4;
  localparam int IW = 2;
  localparam int SW = 2;
  localparam int UW = 3;
`ifdef MSHR_SECONDARY_MERGE_EN
  localparam bit MERGE = 1'b1;
`else
  localparam bit MERGE = 1'b0;
`endif

  logic          clk, rst_n;
  logic          pri_valid, pri_ready, sec_valid, sec_ready, rsp_valid, rsp_ready;
  logic          out_valid, out_ready, out_last, full;
  logic [IW-1:0] pri_idx, sec_idx, rsp_idx, out_idx;
  logic [SW-1:0] out_sub;
  logic [UW-1:0] used;

  l1_mshr_entry_ctrl #(.NUM_ENTRY(NE), .NUM_SUB(NS)) dut (
    .clk(clk), .rst_n(rst_n),
    .pri_valid_i(pri_valid), .pri_ready_o(pri_ready), .pri_idx_o(pri_idx),
    .sec_valid_i(sec_valid), .sec_ready_o(sec_ready), .sec_idx_i(sec_idx),
    .rsp_valid_i(rsp_valid), .rsp_ready_o(rsp_ready), .rsp_idx_i(rsp_idx),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_idx_o(out_idx),
    .out_sub_o(out_sub), .out_last_o(out_last), .used_o(used), .full_o(full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Model: table of entries (valid, merged-request count) plus the entry being replayed.
  bit m_vld[NE], n_vld[NE];
  int m_cnt[NE], n_cnt[NE];
  bit m_drain, n_drain;
  int m_didx, n_didx, m_beat, n_beat;

  initial begin
    for (int i = 0; i < NE; i++) begin n_vld[i] = 0; n_cnt[i] = 0; end
    n_drain = 0; n_didx = 0; n_beat = 0;
  end

  function automatic int m_used();
    int u = 0;
    for (int i = 0; i < NE; i++) if (m_vld[i]) u++;
    return u;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NE; i++) begin m_vld[i] <= 0; m_cnt[i] <= 0; end
      m_drain <= 0; m_didx <= 0; m_beat <= 0;
    end else begin
      m_vld <= n_vld; m_cnt <= n_cnt;
      m_drain <= n_drain; m_didx <= n_didx; m_beat <= n_beat;
    end
  end

  // Compare on the falling edge, then derive what the coming rising edge must do.
  always @(negedge clk) begin : cmp
    int u, pidx, t_cnt[NE], t_didx, t_beat;
    bit pr, rr, rf, sr, last, t_vld[NE], t_drain;
    if (chk_en && rst_n) begin
      u = 0; pidx = 0;
      for (int i = NE - 1; i >= 0; i--) begin
        if (m_vld[i]) u++; else pidx = i;
      end
      pr   = (u < NE);
      rr   = !m_drain && m_vld[rsp_idx];
      rf   = rsp_valid && rr;
      sr   = MERGE && m_vld[sec_idx] && (m_cnt[sec_idx] < NS)
             && !(m_drain && m_didx == int'(sec_idx)) && !(rf && rsp_idx == sec_idx);
      last = m_drain && (m_beat == m_cnt[m_didx] - 1);
      chk("used", used, u);
      chk("full", full, u == NE);
      chk("pri_ready", pri_ready, pr);
      if (pr) chk("pri_idx", pri_idx, pidx);
      chk("rsp_ready", rsp_ready, rr);
      chk("sec_ready", sec_ready, sr);
      chk("out_valid", out_valid, m_drain);
      chk("out_last", out_last, last);
      chk("out_idx", out_idx, m_didx);
      chk("out_sub", out_sub, m_beat);
      t_vld = m_vld; t_cnt = m_cnt; t_drain = m_drain; t_didx = m_didx; t_beat = m_beat;
      if (pri_valid && pr) begin t_vld[pidx] = 1; t_cnt[pidx] = 1; end
      if (sec_valid && sr) t_cnt[sec_idx] = t_cnt[sec_idx] + 1;
      if (m_drain && out_ready) begin
        if (last) begin t_vld[m_didx] = 0; t_cnt[m_didx] = 0; t_drain = 0; end
        else t_beat = t_beat + 1;
      end
      if (rf) begin t_drain = 1; t_didx = rsp_idx; t_beat = 0; end
      n_vld <= t_vld; n_cnt <= t_cnt; n_drain <= t_drain; n_didx <= t_didx; n_beat <= t_beat;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin : stim
    int nsub;
    rst_n = 1'b0;
    pri_valid = 0; sec_valid = 0; rsp_valid = 0; out_ready = 0;
    sec_idx = '0; rsp_idx = '0;
    tick(); tick();
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Post-reset outputs
    chk("rst_pri_ready", pri_ready, 1);
    chk("rst_pri_idx", pri_idx, 0);
    chk("rst_sec_ready", sec_ready, 0);
    chk("rst_rsp_ready", rsp_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_used", used, 0);
    chk("rst_full", full, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_sub", out_sub, 0);
    chk("model_rst_used", m_used(), 0);

    // Response to an invalid entry is held off
    rsp_valid = 1; rsp_idx = 2'd1; #1;
    chk("inv_rsp_ready", rsp_ready, 0);
    tick(); tick();
    chk("inv_out_valid", out_valid, 0);
    chk("inv_used", used, 0);
    rsp_valid = 0;

    // Four back-to-back primaries
    pri_valid = 1;
    for (int k = 0; k < NE; k++) begin
      #1;
      chk("b2b_pri_idx", pri_idx, k);
      chk("b2b_pri_ready", pri_ready, 1);
      tick();
    end
    pri_valid = 0; #1;
    chk("b2b_used", used, 4);
    chk("b2b_full", full, 1);
    chk("b2b_pri_ready", pri_ready, 0);
    chk("model_b2b_used", m_used(), 4);

    // Drain entry 2 from full with a stall, then it is the next allocation
    rsp_valid = 1; rsp_idx = 2'd2; #1;
    chk("full_rsp_ready", rsp_ready, 1);
    tick();
    rsp_valid = 0;
    chk("full_out_valid", out_valid, 1);
    chk("full_out_idx", out_idx, 2);
    chk("full_out_sub", out_sub, 0);
    chk("full_out_last", out_last, 1);
    tick(); tick();
    chk("stall_out_valid", out_valid, 1);
    chk("stall_out_sub", out_sub, 0);
    chk("stall_full", full, 1);
    out_ready = 1;
    tick();
    out_ready = 0;
    chk("free_full", full, 0);
    chk("free_pri_idx", pri_idx, 2);
    chk("free_used", used, 3);
    chk("free_out_valid", out_valid, 0);
    chk("free_out_idx_hold", out_idx, 2);

    // Merge until the entry is full, then replay every sub-entry with a mid-drain stall
    do_reset(); tick();
    pri_valid = 1; tick(); pri_valid = 0;
    sec_valid = 1; sec_idx = 2'd0;
    for (int k = 0; k < NS - 1; k++) begin
      #1;
      chk("merge_sec_ready", sec_ready, MERGE);
      tick();
    end
    #1;
    chk("merge_refused", sec_ready, 0);
    sec_valid = 0;
    nsub = MERGE ? NS : 1;
    rsp_valid = 1; rsp_idx = 2'd0; tick(); rsp_valid = 0;
    for (int b = 0; b < nsub; b++) begin
      chk("drain_out_valid", out_valid, 1);
      chk("drain_out_sub", out_sub, b);
      chk("drain_out_last", out_last, b == nsub - 1);
      if (b == 1) begin
        out_ready = 0; tick(); tick();
        chk("drain_stall_sub", out_sub, 1);
        chk("drain_stall_valid", out_valid, 1);
      end
      out_ready = 1; tick(); out_ready = 0;
    end
    chk("drain_done_used", used, 0);
    chk("drain_done_valid", out_valid, 0);
    chk("drain_done_sub_hold", out_sub, nsub - 1);

    // Reset in the middle of a drain
    pri_valid = 1; tick(); pri_valid = 0;
    if (MERGE) begin sec_valid = 1; sec_idx = 2'd0; tick(); sec_valid = 0; end
    rsp_valid = 1; rsp_idx = 2'd0; tick(); rsp_valid = 0;
    if (MERGE) begin
      out_ready = 1; tick(); out_ready = 0;
      chk("mid_out_sub", out_sub, 1);
    end
    chk("mid_out_valid", out_valid, 1);
    rst_n = 1'b0; #1;
    chk("rstmid_out_valid", out_valid, 0);
    chk("rstmid_used", used, 0);
    chk("rstmid_rsp_ready", rsp_ready, 0);
    tick(); rst_n = 1'b1; tick();
    chk("rstmid_after_valid", out_valid, 0);
    chk("rstmid_after_pri_idx", pri_idx, 0);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      pri_valid = ($urandom_range(0, 3) == 0);
      sec_valid = $urandom_range(0, 1) == 1;
      sec_idx   = IW'($urandom_range(0, NE - 1));
      rsp_valid = ($urandom_range(0, 3) == 0);
      rsp_idx   = IW'($urandom_range(0, NE - 1));
      out_ready = ($urandom_range(0, 3) != 0);
      if (c == 1500) begin
        rst_n = 1'b0; tick(); rst_n = 1'b1;
      end
      tick();
    end
    pri_valid = 0; sec_valid = 0; rsp_valid = 0; out_ready = 0;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
